// File: rtl/pe_pkg.sv
// Shared types and default widths for the PE push streamer slice.
package pe_pkg;

    localparam int PE_DATA_WIDTH  = 64;
    localparam int PE_ADDR_WIDTH  = 12;
    localparam int PE_COUNT_WIDTH = 12;
    localparam int STATS_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } pe_state_e;

endpackage

// File: rtl/pe_push_streamer_if.sv
// Control, source-memory read and PE-FIFO push signals of the push streamer.
interface pe_push_streamer_if
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH  = PE_DATA_WIDTH,
    parameter int ADDR_WIDTH  = PE_ADDR_WIDTH,
    parameter int COUNT_WIDTH = PE_COUNT_WIDTH
) ();

    logic                   enable;
    logic                   configure;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [COUNT_WIDTH-1:0] word_count;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   mem_rd_en;
    logic [ADDR_WIDTH-1:0]  mem_rd_addr;
    logic [DATA_WIDTH-1:0]  mem_rd_data;
    logic                   push;
    logic [DATA_WIDTH-1:0]  data;
    logic                   fifo_full;

    // The streamer drives the memory read port and the FIFO push port.
    modport master (
        input  enable, configure, base_addr, word_count, start, mem_rd_data, fifo_full,
        output busy, done, mem_rd_en, mem_rd_addr, push, data
    );

    modport slave (
        output enable, configure, base_addr, word_count, start, mem_rd_data, fifo_full,
        input  busy, done, mem_rd_en, mem_rd_addr, push, data
    );

endinterface

// File: rtl/pe_skid_buffer.sv
// Two-entry in-order skid buffer with a flow-through path when empty.
module pe_skid_buffer #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic [DATA_WIDTH-1:0] entry_q [2];
    logic                  rdPtr_q, wrPtr_q;
    logic [1:0]            count_q, count_d;
    logic                  bypass, storeEn, popStored;

    // An incoming word skips storage only when nothing is queued ahead of it.
    assign bypass      = (count_q == 2'd0) && in_valid_i && out_ready_i;
    assign storeEn     = in_valid_i && !bypass;
    assign popStored   = (count_q != 2'd0) && out_ready_i;
    assign out_valid_o = (count_q != 2'd0) || in_valid_i;
    assign out_data_o  = (count_q != 2'd0) ? entry_q[rdPtr_q] : in_data_i;
    assign count_d     = count_q + {1'b0, storeEn} - {1'b0, popStored};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rdPtr_q    <= 1'b0;
            wrPtr_q    <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (storeEn) begin
                entry_q[wrPtr_q] <= in_data_i;
                wrPtr_q          <= ~wrPtr_q;
            end
            if (popStored) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pe_push_streamer.sv
// Streams word_count words from a source memory into the PE input FIFO.
// Define PE_STREAM_STATS_EN to add the stall_cycles back-pressure counter.
module pe_push_streamer
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH  = PE_DATA_WIDTH,
    parameter int ADDR_WIDTH  = PE_ADDR_WIDTH,
    parameter int COUNT_WIDTH = PE_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef PE_STREAM_STATS_EN
    output logic [STATS_WIDTH-1:0] stall_cycles,
`endif
    pe_push_streamer_if.master     bus
);

    pe_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]  baseAddr_q, baseAddr_d;
    logic [COUNT_WIDTH-1:0] wordCount_q, wordCount_d;
    logic [COUNT_WIDTH-1:0] readCnt_q, readCnt_d;
    logic [COUNT_WIDTH-1:0] pushCnt_q, pushCnt_d;
    logic                   rdPending_q;

    logic                   active, rdEn, pushReady, pushEn, headValid;
    logic [DATA_WIDTH-1:0]  headData;
    logic [COUNT_WIDTH-1:0] inFlight, startCount;

    // Reads stay at most two ahead of pushes, so the skid buffer never overflows.
    assign active     = (state_q == STREAM) || (state_q == DRAIN);
    assign inFlight   = readCnt_q - pushCnt_q;
    assign rdEn       = bus.enable && (state_q == STREAM)
                        && (inFlight < COUNT_WIDTH'(2)) && (readCnt_q < wordCount_q);
    assign pushReady  = bus.enable && active && !bus.fifo_full;
    assign pushEn     = pushReady && headValid;
    assign startCount = bus.configure ? bus.word_count : wordCount_q;

    pe_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (rdPending_q),
        .in_data_i   (bus.mem_rd_data),
        .out_ready_i (pushReady),
        .out_valid_o (headValid),
        .out_data_o  (headData)
    );

    always_comb begin
        state_d     = state_q;
        baseAddr_d  = baseAddr_q;
        wordCount_d = wordCount_q;
        readCnt_d   = readCnt_q + (rdEn ? COUNT_WIDTH'(1) : '0);
        pushCnt_d   = pushCnt_q + (pushEn ? COUNT_WIDTH'(1) : '0);
        if (bus.enable) begin
            case (state_q)
                IDLE: begin
                    if (bus.configure) begin
                        baseAddr_d  = bus.base_addr;
                        wordCount_d = bus.word_count;
                    end
                    if (bus.start) begin
                        readCnt_d = '0;
                        pushCnt_d = '0;
                        state_d   = (startCount == '0) ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (rdEn && (readCnt_q == wordCount_q - COUNT_WIDTH'(1))) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pushEn && (pushCnt_q == wordCount_q - COUNT_WIDTH'(1))) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            baseAddr_q  <= '0;
            wordCount_q <= '0;
            readCnt_q   <= '0;
            pushCnt_q   <= '0;
            rdPending_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baseAddr_q  <= baseAddr_d;
            wordCount_q <= wordCount_d;
            readCnt_q   <= readCnt_d;
            pushCnt_q   <= pushCnt_d;
            rdPending_q <= rdEn;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.mem_rd_en   = rdEn;
    assign bus.mem_rd_addr = rdEn ? (baseAddr_q + ADDR_WIDTH'(readCnt_q)) : '0;
    assign bus.push        = pushEn;
    assign bus.data        = pushEn ? headData : '0;

`ifdef PE_STREAM_STATS_EN
    logic [STATS_WIDTH-1:0] stall_q, stall_d;

    // Counts cycles where a word is waiting but the FIFO refuses it.
    always_comb begin
        stall_d = stall_q;
        if (bus.enable) begin
            if ((state_q == IDLE) && bus.start) begin
                stall_d = '0;
            end else if (headValid && bus.fifo_full && (stall_q != '1)) begin
                stall_d = stall_q + STATS_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
